// File: rtl/yj_basic_signal_sync_deb_pkg.sv
// Shared types for the synchronizer/debouncer: per-channel debounce state
// and the threshold test used by every channel cell.
package yj_basic_signal_sync_deb_pkg;

  typedef enum logic {
    DEB_STABLE  = 1'b0,
    DEB_PENDING = 1'b1
  } deb_state_e;

  // Counts are zero-extended to 16 bits so one helper serves every DEB_W.
  // Using >= lets a lowered limit take effect on the very next edge.
  function automatic logic limitReached(input logic [15:0] cnt, input logic [15:0] lim);
    return (cnt >= lim);
  endfunction

endpackage

// File: rtl/yj_basic_signal_sync_deb_if.sv
// Bundle of the data/control signals around the synchronizer/debouncer,
// letting a driver and the block be wired as one bus.
interface yj_basic_signal_sync_deb_if #(
  parameter int CH    = 8,
  parameter int DEB_W = 4
);

  logic [CH-1:0]    din;
  logic [DEB_W-1:0] deb_limit;
  logic             bypass;
  logic [CH-1:0]    dout;
  logic [CH-1:0]    rise;
  logic [CH-1:0]    fall;
  logic             chg;

  modport master (
    output din, deb_limit, bypass,
    input  dout, rise, fall, chg
  );

  modport slave (
    input  din, deb_limit, bypass,
    output dout, rise, fall, chg
  );

endinterface

// File: rtl/yj_basic_signal_sync_deb_cell.sv
// One channel of debounce filtering: a STABLE/PENDING counter that only lets
// the synchronized level through after it has held long enough.
module yj_basic_deb_cell
  import yj_basic_signal_sync_deb_pkg::*;
#(
  parameter int   DEB_W  = 4,
  parameter logic RSTVAL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sync_i,
  input  logic [DEB_W-1:0] deb_limit_i,
  input  logic             bypass_i,
  output logic             dout_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             edge_o
);

  deb_state_e       state_q, state_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, fall_q;

  // Edge flags are registered from the next-state so they line up with the
  // first cycle in which dout shows its new value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= DEB_STABLE;
      cnt_q   <= '0;
      dout_q  <= RSTVAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= dout_d & ~dout_q;
      fall_q  <= ~dout_d & dout_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    if (bypass_i) begin
      state_d = DEB_STABLE;
      cnt_d   = '0;
      dout_d  = sync_i;
    end else begin
      case (state_q)
        DEB_STABLE: begin
          if (sync_i != dout_q) begin
            state_d = DEB_PENDING;
            cnt_d   = '0;
          end
        end
        DEB_PENDING: begin
          if (sync_i == dout_q) begin
            state_d = DEB_STABLE;
            cnt_d   = '0;
          end else if (limitReached(16'(cnt_q), 16'(deb_limit_i))) begin
            state_d = DEB_STABLE;
            cnt_d   = '0;
            dout_d  = sync_i;
          end else begin
            // Cannot wrap: at the all-ones count limitReached is always true.
            cnt_d = cnt_q + DEB_W'(1);
          end
        end
      endcase
    end
  end

  assign dout_o = dout_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign edge_o = dout_d ^ dout_q;

endmodule

// File: rtl/yj_basic_signal_sync_deb.sv
// Multi-channel input conditioner: a per-bit synchronizer chain feeding one
// debounce cell per channel, plus a registered any-change flag.
module yj_basic_signal_sync_deb
  import yj_basic_signal_sync_deb_pkg::*;
#(
  parameter int   CH          = 8,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_W       = 4,
  parameter logic RSTVAL      = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CH-1:0]    din,
  input  logic [DEB_W-1:0] deb_limit,
  input  logic             bypass,
  output logic [CH-1:0]    dout,
  output logic [CH-1:0]    rise,
  output logic [CH-1:0]    fall,
  output logic             chg
);

  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] edge_w;
  logic          chg_q;

  // Stage 0 is the only flop that sees the asynchronous inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {CH{RSTVAL}};
      end
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_cell
    yj_basic_deb_cell #(
      .DEB_W  (DEB_W),
      .RSTVAL (RSTVAL)
    ) u_cell (
      .CLK         (CLK),
      .RST         (RST),
      .sync_i      (sync_q[SYNC_STAGES-1][i]),
      .deb_limit_i (deb_limit),
      .bypass_i    (bypass),
      .dout_o      (dout[i]),
      .rise_o      (rise[i]),
      .fall_o      (fall[i]),
      .edge_o      (edge_w[i])
    );
  end

  // Built from the cells' next-edge flags so chg lands with rise/fall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= |edge_w;
    end
  end

  assign chg = chg_q;

endmodule

// File: tb/tb_yj_basic_signal_sync_deb.sv
// Self-checking bench for yj_basic_signal_sync_deb: table vectors, a queued
// scoreboard fed by a behavioural model, and latency/pulse spot checks.
module tb_yj_basic_signal_sync_deb;

  localparam int   CH      = 8;
  localparam int   SYNC    = 2;
  localparam int   DEB_W   = 4;
  localparam logic RSTVAL  = 1'b0;
  localparam int   NOM_LAT = 6;

  typedef struct packed {
    logic [7:0] dout;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    exp_t       e;
  } vec_t;

  typedef struct {
    exp_t  e;
    string tag;
  } sb_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  yj_basic_signal_sync_deb_if #(.CH(CH), .DEB_W(DEB_W)) bus ();

  yj_basic_signal_sync_deb #(
    .CH          (CH),
    .SYNC_STAGES (SYNC),
    .DEB_W       (DEB_W),
    .RSTVAL      (RSTVAL)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .din       (bus.din),
    .deb_limit (bus.deb_limit),
    .bypass    (bus.bypass),
    .dout      (bus.dout),
    .rise      (bus.rise),
    .fall      (bus.fall),
    .chg       (bus.chg)
  );

  always #5 CLK = ~CLK;

  int  vectors = 0;
  int  miscompares = 0;
  sb_t sbq[$];

  logic [7:0] mS [SYNC];
  int         mCnt [8];
  bit         mPend [8];
  logic [7:0] mDout = '0;

  int         wEdge, wFirst, wLast, wChg;
  logic [7:0] wFirstRise, wFirstFall;

  // Behavioural reference: sync chain as a shift list, per-channel counter.
  task automatic modelStep(input logic r, input logic [7:0] d, input logic [3:0] l,
                           input logic b, output exp_t e);
    logic [7:0] sync, nd;
    if (r) begin
      for (int k = 0; k < SYNC; k++) mS[k] = {8{RSTVAL}};
      for (int i = 0; i < 8; i++) begin mCnt[i] = 0; mPend[i] = 0; end
      mDout = {8{RSTVAL}};
      e = '{dout: {8{RSTVAL}}, rise: 8'h00, fall: 8'h00, chg: 1'b0};
    end else begin
      sync = mS[SYNC-1];
      nd   = mDout;
      for (int i = 0; i < 8; i++) begin
        if (b) begin
          nd[i] = sync[i]; mCnt[i] = 0; mPend[i] = 0;
        end else if (!mPend[i]) begin
          if (sync[i] != mDout[i]) begin mPend[i] = 1; mCnt[i] = 0; end
        end else if (sync[i] == mDout[i]) begin
          mPend[i] = 0; mCnt[i] = 0;
        end else if (mCnt[i] >= int'(l)) begin
          nd[i] = sync[i]; mPend[i] = 0; mCnt[i] = 0;
        end else begin
          mCnt[i]++;
        end
      end
      e.dout = nd;
      e.rise = nd & ~mDout;
      e.fall = ~nd & mDout;
      e.chg  = |(e.rise | e.fall);
      mDout  = nd;
      for (int k = SYNC - 1; k > 0; k--) mS[k] = mS[k-1];
      mS[0] = d;
    end
  endtask

  task automatic startWatch();
    wEdge = 0; wFirst = -1; wLast = -1; wChg = 0;
    wFirstRise = '0; wFirstFall = '0;
  endtask

  task automatic checkOutput();
    sb_t  s;
    exp_t got;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard: output seen with no queued expectation");
    end else begin
      s   = sbq.pop_front();
      got = {bus.dout, bus.rise, bus.fall, bus.chg};
      if (got !== s.e) begin
        miscompares++;
        $display("[TB] FAIL %s: got dout=%h rise=%h fall=%h chg=%b, want dout=%h rise=%h fall=%h chg=%b",
                 s.tag, got.dout, got.rise, got.fall, got.chg,
                 s.e.dout, s.e.rise, s.e.fall, s.e.chg);
      end
    end
    if (bus.chg === 1'b1) begin
      if (wFirst < 0) begin
        wFirst = wEdge; wFirstRise = bus.rise; wFirstFall = bus.fall;
      end
      wLast = wEdge;
      wChg++;
    end
    wEdge++;
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] d, input logic [3:0] l,
                               input logic b, input bit useExp, input exp_t te,
                               input string tag);
    exp_t me;
    sb_t  s;
    RST           = r;
    bus.din       = d;
    bus.deb_limit = l;
    bus.bypass    = b;
    modelStep(r, d, l, b, me);
    s.e   = useExp ? te : me;
    s.tag = tag;
    sbq.push_back(s);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  task automatic run(input int n, input logic r, input logic [7:0] d, input logic [3:0] l,
                     input logic b, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(r, d, l, b, 1'b0, '0, tag);
  endtask

  task automatic expectInt(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic expectVec(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  vec_t tbl [16];

  initial begin
    for (int k = 0; k < 16; k++) begin
      tbl[k].din    = (k < 8) ? 8'h01 : 8'h00;
      tbl[k].e.dout = (k >= NOM_LAT && k < 8 + NOM_LAT) ? 8'h01 : 8'h00;
      tbl[k].e.rise = (k == NOM_LAT) ? 8'h01 : 8'h00;
      tbl[k].e.fall = (k == 8 + NOM_LAT) ? 8'h01 : 8'h00;
      tbl[k].e.chg  = (k == NOM_LAT) || (k == 8 + NOM_LAT);
    end
    for (int k = 0; k < SYNC; k++) mS[k] = '0;
    for (int i = 0; i < 8; i++) begin mCnt[i] = 0; mPend[i] = 0; end
    bus.din = '0; bus.deb_limit = 4'd3; bus.bypass = 1'b0; RST = 1'b1;
    #2;

    startWatch();
    run(3, 1'b1, 8'hFF, 4'd3, 1'b0, "reset_hold");
    expectInt("reset_pulses", wChg, 0);

    startWatch();
    run(10, 1'b0, 8'hFF, 4'd3, 1'b0, "release");
    expectInt("release_edge", wFirst, SYNC + 3 + 1);
    expectVec("release_rise", wFirstRise, 8'hFF);
    expectInt("release_pulses", wChg, 1);

    startWatch();
    run(10, 1'b0, 8'h00, 4'd3, 1'b0, "toggle_all");
    expectInt("toggle_edge", wFirst, NOM_LAT);
    expectVec("toggle_fall", wFirstFall, 8'hFF);
    expectInt("toggle_pulses", wChg, 1);

    for (int k = 0; k < 16; k++)
      applyStimulus(1'b0, tbl[k].din, 4'd3, 1'b0, 1'b1, tbl[k].e, $sformatf("nominal[%0d]", k));

    startWatch();
    run(3, 1'b0, 8'h02, 4'd3, 1'b0, "glitch_short");
    run(8, 1'b0, 8'h00, 4'd3, 1'b0, "glitch_short_tail");
    expectInt("glitch_rejected", wChg, 0);

    startWatch();
    run(5, 1'b0, 8'h02, 4'd3, 1'b0, "pulse_long");
    run(12, 1'b0, 8'h00, 4'd3, 1'b0, "pulse_long_tail");
    expectInt("pulse_rise_edge", wFirst, NOM_LAT);
    expectVec("pulse_rise", wFirstRise, 8'h02);
    expectInt("pulse_fall_edge", wLast, 5 + NOM_LAT);
    expectInt("pulse_count", wChg, 2);

    startWatch();
    run(1, 1'b0, 8'h04, 4'd3, 1'b1, "bypass_pulse");
    run(5, 1'b0, 8'h00, 4'd3, 1'b1, "bypass_tail");
    expectInt("bypass_rise_edge", wFirst, SYNC);
    expectVec("bypass_rise", wFirstRise, 8'h04);
    expectInt("bypass_fall_edge", wLast, SYNC + 1);
    expectInt("bypass_count", wChg, 2);
    startWatch();
    run(4, 1'b0, 8'h00, 4'd3, 1'b0, "bypass_off");
    expectInt("bypass_off_pulses", wChg, 0);

    startWatch();
    run(20, 1'b0, 8'h08, 4'd15, 1'b0, "limit_max");
    expectInt("limit_max_edge", wFirst, 18);
    expectVec("limit_max_rise", wFirstRise, 8'h08);
    startWatch();
    run(8, 1'b0, 8'h00, 4'd3, 1'b0, "limit_max_restore");
    expectInt("limit_max_restore_edge", wFirst, NOM_LAT);

    startWatch();
    run(8, 1'b0, 8'h10, 4'd10, 1'b0, "limit_hi");
    run(4, 1'b0, 8'h10, 4'd2, 1'b0, "limit_lowered");
    expectInt("limit_lowered_edge", wFirst, 8);
    expectVec("limit_lowered_rise", wFirstRise, 8'h10);
    run(8, 1'b0, 8'h00, 4'd3, 1'b0, "limit_restore");

    startWatch();
    run(5, 1'b0, 8'h20, 4'd3, 1'b0, "pre_reset");
    run(2, 1'b1, 8'h20, 4'd3, 1'b0, "mid_reset");
    expectInt("mid_reset_pulses", wChg, 0);
    startWatch();
    run(10, 1'b0, 8'h20, 4'd3, 1'b0, "post_reset");
    expectInt("post_reset_edge", wFirst, NOM_LAT);
    expectVec("post_reset_rise", wFirstRise, 8'h20);
    expectInt("post_reset_pulses", wChg, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
